// File: rtl/shift_operand_pipe.sv
// Two-stage valid/ready pipelined ARM operand-2 generator (Val2 + shifter carry-out).
// S1 decodes the instruction into a uniform (op, amount, operand) form; S2 performs the shift.
module shift_operand_pipe #(
   parameter int DATA_W     = 32,
   parameter int LDST_OFF_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              ldst,
   input  logic              imm,
   input  logic [11:0]       shift_operand,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [7:0]        val_rs,
   input  logic              carry_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] val2,
   output logic              shifter_carry
);
   localparam int AW    = $clog2(DATA_W);
   localparam int OFF_W = (LDST_OFF_W > 12) ? 12 : LDST_OFF_W;

   typedef enum logic [2:0] {OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_e;

   op_e               dec_op, s1_op_d, s1_op_q;
   logic [7:0]        dec_amt, s1_amt_d, s1_amt_q;
   logic [DATA_W-1:0] dec_opnd, s1_opnd_d, s1_opnd_q;
   logic              s1_valid_d, s1_valid_q, s1_cin_d, s1_cin_q;
   logic              out_valid_d, out_valid_q, carry_d, carry_q;
   logic [DATA_W-1:0] val2_d, val2_q;
   logic              s2_adv, s1_adv;
   logic [7:0]        rot_amt, imm_amt;
   logic [1:0]        sh_type;

   logic [AW-1:0]       sh, lsl_idx, rsh_idx;
   logic [2*DATA_W-1:0] rot;
   logic                big, at_w, cout;
   logic [DATA_W-1:0]   res;

   assign s2_adv        = !out_valid_q || out_ready;
   assign s1_adv        = s1_valid_q && s2_adv;
   assign in_ready      = !s1_valid_q || s2_adv;
   assign out_valid     = out_valid_q;
   assign val2          = val2_q;
   assign shifter_carry = carry_q;

   // Decode: every mode is reduced to an op plus an 8-bit effective amount.
   // Immediate LSR/ASR #0 become amount DATA_W so S2 treats them like register shifts.
   always_comb begin
      sh_type  = shift_operand[6:5];
      imm_amt  = {3'b000, shift_operand[11:7]};
      rot_amt  = {3'b000, shift_operand[11:8], 1'b0} & 8'(DATA_W - 1);
      dec_op   = OP_PASS;
      dec_amt  = 8'd0;
      dec_opnd = val_rm;
      if (ldst) begin
         dec_opnd = DATA_W'(shift_operand[OFF_W-1:0]);
      end else if (imm) begin
         dec_opnd = DATA_W'(shift_operand[7:0]);
         dec_amt  = rot_amt;
         if (rot_amt != 8'd0) dec_op = OP_ROR;
      end else if (shift_operand[4]) begin
         dec_amt = val_rs;
         if (val_rs != 8'd0) begin
            case (sh_type)
               2'd0:    dec_op = OP_LSL;
               2'd1:    dec_op = OP_LSR;
               2'd2:    dec_op = OP_ASR;
               default: dec_op = OP_ROR;
            endcase
         end
      end else begin
         dec_amt = imm_amt;
         case (sh_type)
            2'd0: dec_op = (imm_amt == 8'd0) ? OP_PASS : OP_LSL;
            2'd1: begin
               dec_op = OP_LSR;
               if (imm_amt == 8'd0) dec_amt = 8'(DATA_W);
            end
            2'd2: begin
               dec_op = OP_ASR;
               if (imm_amt == 8'd0) dec_amt = 8'(DATA_W);
            end
            default: dec_op = (imm_amt == 8'd0) ? OP_RRX : OP_ROR;
         endcase
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_amt_d   = s1_amt_q;
      s1_opnd_d  = s1_opnd_q;
      s1_cin_d   = s1_cin_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_op_d   = dec_op;
            s1_amt_d  = dec_amt;
            s1_opnd_d = dec_opnd;
            s1_cin_d  = carry_in;
         end
      end
   end

   // Shifter. Low AW amount bits are the in-range shift; 'big' covers amounts >= DATA_W.
   always_comb begin
      sh      = s1_amt_q[AW-1:0];
      lsl_idx = -sh;
      rsh_idx = sh - AW'(1);
      big     = s1_amt_q >= 8'(DATA_W);
      at_w    = s1_amt_q == 8'(DATA_W);
      rot     = {s1_opnd_q, s1_opnd_q} >> sh;
      res     = s1_opnd_q;
      cout    = s1_cin_q;
      case (s1_op_q)
         OP_LSL: begin
            if (!big) begin
               res  = s1_opnd_q << sh;
               cout = s1_opnd_q[lsl_idx];
            end else begin
               res  = '0;
               cout = at_w & s1_opnd_q[0];
            end
         end
         OP_LSR: begin
            if (!big) begin
               res  = s1_opnd_q >> sh;
               cout = s1_opnd_q[rsh_idx];
            end else begin
               res  = '0;
               cout = at_w & s1_opnd_q[DATA_W-1];
            end
         end
         OP_ASR: begin
            if (!big) begin
               res  = DATA_W'($signed(s1_opnd_q) >>> sh);
               cout = s1_opnd_q[rsh_idx];
            end else begin
               res  = {DATA_W{s1_opnd_q[DATA_W-1]}};
               cout = s1_opnd_q[DATA_W-1];
            end
         end
         // A zero residual rotate leaves the operand intact, so its MSB is the carry either way.
         OP_ROR: begin
            res  = rot[DATA_W-1:0];
            cout = rot[DATA_W-1];
         end
         OP_RRX: begin
            res  = {s1_cin_q, s1_opnd_q[DATA_W-1:1]};
            cout = s1_opnd_q[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      val2_d      = val2_q;
      carry_d     = carry_q;
      if (s2_adv) out_valid_d = s1_valid_q;
      if (s1_adv) begin
         val2_d  = res;
         carry_d = cout;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= OP_PASS;
         s1_amt_q    <= 8'd0;
         s1_opnd_q   <= '0;
         s1_cin_q    <= 1'b0;
         out_valid_q <= 1'b0;
         val2_q      <= '0;
         carry_q     <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_amt_q    <= s1_amt_d;
         s1_opnd_q   <= s1_opnd_d;
         s1_cin_q    <= s1_cin_d;
         out_valid_q <= out_valid_d;
         val2_q      <= val2_d;
         carry_q     <= carry_d;
      end
   end
endmodule

// File: tb/tb_shift_operand_pipe.sv
// Bench for shift_operand_pipe: directed vector table, back-pressure / reset sequences,
// random traffic against a spec-level reference model, plus a DATA_W=16 instance.
module tb_shift_operand_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, in_ready, ldst, imm, carry_in, out_valid, out_ready, shifter_carry;
   logic [11:0] shift_operand;
   logic [31:0] val_rm, val2;
   logic [7:0]  val_rs;

   logic        h_in_valid, h_in_ready, h_ldst, h_imm, h_cin, h_out_valid, h_out_ready, h_carry;
   logic [11:0] h_so;
   logic [15:0] h_rm, h_val2;
   logic [7:0]  h_rs;

   shift_operand_pipe #(.DATA_W(32), .LDST_OFF_W(12)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ldst(ldst), .imm(imm),
      .shift_operand(shift_operand), .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
      .out_valid(out_valid), .out_ready(out_ready), .val2(val2), .shifter_carry(shifter_carry));

   shift_operand_pipe #(.DATA_W(16), .LDST_OFF_W(12)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .ldst(h_ldst), .imm(h_imm),
      .shift_operand(h_so), .val_rm(h_rm), .val_rs(h_rs), .carry_in(h_cin),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .val2(h_val2), .shifter_carry(h_carry));

   typedef struct {
      logic l, i; logic [11:0] so; logic [31:0] rm; logic [7:0] rs; logic ci;
      logic [31:0] ev; logic ec;
   } vec_t;

   int          errs = 0, checks = 0;
   logic [32:0] exp_q[$];
   vec_t        tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
      if (r == 0) return x;
      return (x >> r) | (x << (32 - r));
   endfunction

   function automatic logic [31:0] asr(input logic [31:0] x, input int a);
      if (x[31]) return (x >> a) | ~(32'hFFFF_FFFF >> a);
      return x >> a;
   endfunction

   // Reference model: operand-2 rules evaluated directly with integer arithmetic.
   function automatic logic [32:0] model(input vec_t v);
      logic [31:0] rm, r;
      logic        c;
      int          a, t;
      rm = v.rm; r = rm; c = v.ci; t = int'(v.so[6:5]);
      if (v.l) begin
         r = {20'd0, v.so};
      end else if (v.i) begin
         a = (2 * int'(v.so[11:8])) % 32;
         r = rotr({24'd0, v.so[7:0]}, a);
         if (a != 0) c = r[31];
      end else if (v.so[4]) begin
         a = int'(v.rs);
         if (a != 0) begin
            if (t == 0) begin
               if (a < 32) begin r = rm << a; c = rm[32-a]; end
               else begin r = 0; c = (a == 32) ? rm[0] : 1'b0; end
            end else if (t == 1) begin
               if (a < 32) begin r = rm >> a; c = rm[a-1]; end
               else begin r = 0; c = (a == 32) ? rm[31] : 1'b0; end
            end else if (t == 2) begin
               if (a < 32) begin r = asr(rm, a); c = rm[a-1]; end
               else begin r = {32{rm[31]}}; c = rm[31]; end
            end else begin
               r = rotr(rm, a % 32);
               c = (a % 32 == 0) ? rm[31] : r[31];
            end
         end
      end else begin
         a = int'(v.so[11:7]);
         if (t == 0) begin
            if (a > 0) begin r = rm << a; c = rm[32-a]; end
         end else if (t == 1) begin
            if (a == 0) begin r = 0; c = rm[31]; end
            else begin r = rm >> a; c = rm[a-1]; end
         end else if (t == 2) begin
            if (a == 0) begin r = {32{rm[31]}}; c = rm[31]; end
            else begin r = asr(rm, a); c = rm[a-1]; end
         end else begin
            if (a == 0) begin r = {v.ci, rm[31:1]}; c = rm[0]; end
            else begin r = rotr(rm, a); c = r[31]; end
         end
      end
      return {c, r};
   endfunction

   task automatic drive(input vec_t v);
      ldst = v.l; imm = v.i; shift_operand = v.so; val_rm = v.rm; val_rs = v.rs; carry_in = v.ci;
   endtask

   // Called at a negedge with inputs set; scores this cycle's handshakes, returns at next negedge.
   task automatic tick(input logic [32:0] exp, output bit acc);
      logic [32:0] e;
      #1;
      acc = 1'b0;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errs++;
            $display("FAIL unexpected_out: got %0h expected none", val2);
         end else begin
            e = exp_q.pop_front();
            check("out_val2", 64'(val2), 64'(e[31:0]));
            check("out_carry", 64'(shifter_carry), 64'(e[32]));
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(exp);
         acc = 1'b1;
      end
      @(negedge clk);
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      v.l  = ($urandom_range(0, 7) == 0);
      v.i  = ($urandom_range(0, 3) == 0);
      v.so = 12'($urandom);
      case ($urandom_range(0, 3))
         0:       v.rm = 32'h8000_0001;
         1:       v.rm = 32'hFFFF_FFFF;
         default: v.rm = $urandom;
      endcase
      case ($urandom_range(0, 3))
         0: v.rs = 8'($urandom_range(0, 255));
         1: v.rs = 8'($urandom_range(0, 40));
         2: v.rs = 8'd32;
         default: v.rs = ($urandom_range(0, 1) != 0) ? 8'd64 : 8'd33;
      endcase
      v.ci = 1'($urandom);
      v.ev = '0; v.ec = 1'b0;
      return v;
   endfunction

   function automatic vec_t mk(input logic l, input logic i, input logic [11:0] so, input logic [31:0] rm,
                               input logic [7:0] rs, input logic ci, input logic [31:0] ev, input logic ec);
      vec_t v;
      v.l = l; v.i = i; v.so = so; v.rm = rm; v.rs = rs; v.ci = ci; v.ev = ev; v.ec = ec;
      return v;
   endfunction

   initial begin
      #300000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bit          acc;
      vec_t        bp[4];
      vec_t        v;
      int          idx;
      logic [31:0] held;
      bit          have_held;
      logic [32:0] cur;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ldst = 0; imm = 0; shift_operand = '0; val_rm = '0; val_rs = '0; carry_in = 0;
      h_in_valid = 0; h_out_ready = 1; h_ldst = 0; h_imm = 0; h_so = '0; h_rm = '0; h_rs = '0; h_cin = 0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_val2", 64'(val2), 64'd0);
      check("rst_carry", 64'(shifter_carry), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      @(negedge clk);
      rst_n = 1'b1;
      imm = 1; shift_operand = 12'h4FF; carry_in = 0; in_valid = 1;
      @(posedge clk); #1;
      check("lat_cycle1_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      in_valid = 0; imm = 0;
      @(posedge clk); #1;
      check("lat_cycle2_out_valid", 64'(out_valid), 64'd1);
      check("lat_val2", 64'(val2), 64'hFF00_0000);
      check("lat_carry", 64'(shifter_carry), 64'd1);
      repeat (2) @(negedge clk);

      // Directed vectors, applied back-to-back
      tbl.push_back(mk(0, 0, 12'h020, 32'h8000_0001, 8'd0,   1, 32'h0000_0000, 1)); // LSR #0
      tbl.push_back(mk(0, 0, 12'h040, 32'h8000_0001, 8'd0,   1, 32'hFFFF_FFFF, 1)); // ASR #0
      tbl.push_back(mk(0, 0, 12'h060, 32'h8000_0001, 8'd0,   1, 32'hC000_0000, 1)); // RRX
      tbl.push_back(mk(0, 0, 12'h080, 32'h8000_0001, 8'd0,   1, 32'h0000_0002, 1)); // LSL #1
      tbl.push_back(mk(0, 0, 12'hF80, 32'h8000_0001, 8'd0,   1, 32'h8000_0000, 0)); // LSL #31
      tbl.push_back(mk(0, 0, 12'h240, 32'h8000_0001, 8'd0,   1, 32'hF800_0000, 0)); // ASR #4
      tbl.push_back(mk(0, 0, 12'h010, 32'h8000_0001, 8'd32,  1, 32'h0000_0000, 1)); // reg LSL 32
      tbl.push_back(mk(0, 0, 12'h010, 32'h8000_0001, 8'd64,  1, 32'h0000_0000, 0)); // reg LSL 64
      tbl.push_back(mk(0, 0, 12'h030, 32'h8000_0001, 8'd33,  1, 32'h0000_0000, 0)); // reg LSR 33
      tbl.push_back(mk(0, 0, 12'h030, 32'h8000_0001, 8'd32,  0, 32'h0000_0000, 1)); // reg LSR 32
      tbl.push_back(mk(0, 0, 12'h050, 32'h8000_0001, 8'd0,   0, 32'h8000_0001, 0)); // reg ASR 0
      tbl.push_back(mk(0, 0, 12'h050, 32'h8000_0001, 8'd200, 0, 32'hFFFF_FFFF, 1)); // reg ASR 200
      tbl.push_back(mk(0, 0, 12'h070, 32'h8000_0001, 8'd64,  0, 32'h8000_0001, 1)); // reg ROR 64
      tbl.push_back(mk(0, 0, 12'h070, 32'h8000_0001, 8'd4,   1, 32'h1800_0000, 0)); // reg ROR 4
      tbl.push_back(mk(1, 1, 12'hFFF, 32'h1234_5678, 8'd0,   1, 32'h0000_0FFF, 1)); // ldst wins
      tbl.push_back(mk(1, 1, 12'hFFF, 32'h1234_5678, 8'd0,   0, 32'h0000_0FFF, 0));
      tbl.push_back(mk(0, 1, 12'h1FF, 32'h0,         8'd0,   0, 32'hC000_003F, 1)); // imm rot 2
      tbl.push_back(mk(0, 1, 12'hF01, 32'h0,         8'd0,   1, 32'h0000_0004, 0)); // imm rot 30
      tbl.push_back(mk(0, 1, 12'h0AB, 32'h0,         8'd0,   1, 32'h0000_00AB, 1)); // imm rot 0
      out_ready = 1;
      foreach (tbl[k]) begin
         drive(tbl[k]);
         in_valid = 1;
         tick({tbl[k].ec, tbl[k].ev}, acc);
      end
      in_valid = 0;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick('0, acc);
      check("table_drained", 64'(exp_q.size()), 64'd0);

      // Back-pressure: 4 requests with out_ready low
      for (int k = 0; k < 4; k++) bp[k] = rand_vec();
      out_ready = 0; idx = 0; have_held = 0; held = '0;
      for (int k = 0; k < 5; k++) begin
         drive(bp[idx]);
         in_valid = (idx < 4);
         if (out_valid) begin
            if (have_held) check("stall_val2_stable", 64'(val2), 64'(held));
            held = val2; have_held = 1;
         end
         tick(model(bp[idx]), acc);
         if (acc) idx++;
      end
      check("bp_accepts", 64'(idx), 64'd2);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      out_ready = 1;
      for (int k = 0; k < 20 && (idx < 4 || exp_q.size() != 0); k++) begin
         if (idx < 4) drive(bp[idx]);
         in_valid = (idx < 4);
         tick(model(bp[idx < 4 ? idx : 3]), acc);
         if (acc) idx++;
      end
      in_valid = 0;
      check("bp_all_sent", 64'(idx), 64'd4);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Reset with two requests in flight
      for (int k = 0; k < 2; k++) begin
         v = rand_vec(); drive(v); in_valid = 1;
         tick(model(v), acc);
      end
      in_valid = 0; rst_n = 0;
      @(posedge clk); #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_val2", 64'(val2), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check("post_rst_no_stale", 64'(out_valid), 64'd0);
      end
      @(negedge clk);

      // Random traffic with random back-pressure
      acc = 0; cur = '0;
      for (int k = 0; k < 400; k++) begin
         if (!in_valid || acc) begin
            if ($urandom_range(0, 3) != 0) begin
               v = rand_vec(); drive(v); cur = model(v); in_valid = 1;
            end else begin
               in_valid = 0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick(cur, acc);
      end
      in_valid = 0; out_ready = 1;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick('0, acc);
      check("rand_drained", 64'(exp_q.size()), 64'd0);

      // DATA_W=16 instance
      for (int k = 0; k < 3; k++) begin
         logic [15:0] ev; logic ec;
         case (k)
            0: begin h_imm = 0; h_so = 12'h030; h_rm = 16'h8000; h_rs = 8'd16; h_cin = 0; ev = 16'h0000; ec = 1; end
            1: begin h_imm = 0; h_so = 12'h010; h_rm = 16'h8001; h_rs = 8'd16; h_cin = 0; ev = 16'h0000; ec = 1; end
            default: begin h_imm = 1; h_so = 12'h9FF; h_rm = 16'h0; h_rs = 8'd0; h_cin = 0; ev = 16'hC03F; ec = 1; end
         endcase
         h_in_valid = 1;
         @(posedge clk);
         @(negedge clk);
         h_in_valid = 0;
         @(posedge clk); #1;
         check("w16_out_valid", 64'(h_out_valid), 64'd1);
         check("w16_val2", 64'(h_val2), 64'(ev));
         check("w16_carry", 64'(h_carry), 64'(ec));
         repeat (2) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/shift_operand_pipe.md
Name: shift_operand_pipe

Overview:
- Pipelined, handshaked successor to the combinational operand-2 generator.
- Computes the ARM operand-2 value (Val2) and the shifter carry-out for three cases:
  - immediate-rotate operands;
  - immediate-shift operands;
  - register-specified (Rs) shifts.
- Parametrised data width, with full ARM boundary semantics.
- Sits between the ID/EXE pipeline register and the ALU. Two-stage internal pipeline with valid/ready back-pressure.

Parameters:
- DATA_W, 32, datapath width; power of 2, 8..64.
- LDST_OFF_W, 12, width of the load/store immediate offset field; must be at most DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- ldst  input  1  load/store offset mode
- imm  input  1  I bit, immediate-rotate mode
- shift_operand  input  12  instruction bits [11:0]
- val_rm  input  DATA_W  Rm value
- val_rs  input  8  Rs[7:0], the register shift amount
- carry_in  input  1  current CPSR C flag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- val2  output  DATA_W  operand-2 result
- shifter_carry  output  1  shifter carry-out

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk.
  - While rst_n=0 at an edge: s1_valid=0, out_valid=0, val2=0, shifter_carry=0.
  - Reset mid-operation discards all in-flight requests; nothing is produced afterwards.
- Handshake:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - Stage S1 registers decoded mode, type, effective amount, operands and carry_in.
  - Stage S2 registers val2 and shifter_carry.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational).
- Stall: while out_valid && !out_ready, val2 and shifter_carry hold stable, and S1 holds.
- Latency: 2 cycles from input accept to out_valid, with no stall. Throughput is 1 per cycle when out_ready=1.
- Mode priority: ldst > imm > register shift (shift_operand[4]=1) > immediate shift.
- ldst:
  - val2 = zero-extended shift_operand[LDST_OFF_W-1:0].
  - carry = carry_in.
- imm:
  - val2 = zero-extended shift_operand[7:0], rotated right by (2*shift_operand[11:8]) mod DATA_W.
  - carry = carry_in if the rotate amount is 0, else val2[DATA_W-1].
- Immediate shift: amt = shift_operand[11:7], type = shift_operand[6:5].
  - LSL, amt 0: val2 = Rm, carry = carry_in.
  - LSL, amt > 0: val2 = Rm << amt, carry = Rm[DATA_W-amt].
  - LSR, amt 0 (means DATA_W): val2 = 0, carry = Rm[DATA_W-1].
  - LSR, amt > 0: logical right shift, carry = Rm[amt-1].
  - ASR, amt 0: val2 = all Rm[DATA_W-1], carry = Rm[DATA_W-1].
  - ASR, amt > 0: arithmetic right shift, carry = Rm[amt-1].
  - ROR, amt 0 (RRX): val2 = {carry_in, Rm[DATA_W-1:1]}, carry = Rm[0].
  - ROR, amt > 0: rotate right, carry = val2[DATA_W-1].
- Register shift: amt = val_rs[7:0].
  - amt 0, any type: val2 = Rm, carry = carry_in.
  - LSL, amt < DATA_W: as the immediate case.
  - LSL, amt = DATA_W: val2 = 0, carry = Rm[0].
  - LSL, amt > DATA_W: val2 = 0, carry = 0.
  - LSR, amt < DATA_W: as the immediate case.
  - LSR, amt = DATA_W: val2 = 0, carry = Rm[DATA_W-1].
  - LSR, amt > DATA_W: val2 = 0, carry = 0.
  - ASR, amt >= DATA_W: val2 = all sign bits, carry = sign.
  - ROR: r = amt mod DATA_W.
    - r = 0: val2 = Rm, carry = Rm[DATA_W-1].
    - else: rotate right by r, carry = val2[DATA_W-1].
- Register-shift amounts are compared on the full 8 bits, never truncated.
- All results are exactly DATA_W bits. No X propagation when valid=0; stage registers are don't-care.
- Simultaneous events:
  - Accept and emit in the same cycle: both occur, and the pipeline stays full.
  - in_valid with in_ready=0: the request is not captured, and the source must hold it.

Test Plan:
- Reset and latency:
  - Hold rst_n=0 for 2 cycles: out_valid=0, val2=0, in_ready=1.
  - Release reset. Send imm=1, shift_operand=0x4FF, carry_in=0:
    - 2 cycles later val2=0xFF000000, shifter_carry=1.
- Immediate-shift specials, back-to-back with val_rm=0x80000001, carry_in=1:
  - LSR#0 -> val2=0, carry=1.
  - ASR#0 -> val2=0xFFFFFFFF, carry=1.
  - RRX -> val2=0xC0000000, carry=1.
  - LSL#1 -> val2=0x00000002, carry=1.
- Register shift, val_rm=0x80000001:
  - val_rs=32 LSL -> val2=0, carry=1.
  - val_rs=33 LSR -> val2=0, carry=0.
  - val_rs=0 ASR, carry_in=0 -> val2=0x80000001, carry=0.
  - val_rs=64 ROR -> val2=0x80000001, carry=1.
- Load/store: ldst=1, imm=1, shift_operand=0xFFF -> val2=0x00000FFF (zero-extended, ldst wins), carry=carry_in.
- Back-pressure:
  - Stream 4 requests, hold out_ready=0 for 3 cycles: in_ready drops after 2 accepts, and val2 stays stable.
  - Release out_ready: results appear in order, with none lost or duplicated.
- Reset mid-stream with 2 requests in flight: out_valid=0 the next cycle, and no stale result appears after reset release.
- DATA_W=16 build: register LSR with val_rs=16, val_rm=0x8000 -> val2=0, carry=1.
